// File: rtl/uwasic_onboarding_ryan_wang_if.sv
// Purpose : three-wire SPI bus bundle (SCLK, COPI, nCS) used between the
//           tile pins and the SPI register receiver.
// Modports: master - drives sclk/copi/ncs
//           slave  - receives sclk/copi/ncs
interface uwasic_onboarding_ryan_wang_if;
  logic sclk;
  logic copi;
  logic ncs;

  modport master (output sclk, output copi, output ncs);
  modport slave  (input  sclk, input  copi, input  ncs);
endinterface

// File: rtl/uwasic_onboarding_ryan_wang.sv
// Purpose : Tiny Tapeout tile: SPI-written configuration registers driving
//           16 output channels as static-low, static-high or shared PWM.
// Ports   : clk     - system clock
//           rst_n   - synchronous reset, active-high (asserted when 1)
//           ena     - tile select, ignored
//           ui_in   - [0]=SCLK [1]=COPI [2]=nCS, [7:3] unused
//           uo_out  - channels 7:0
//           uio_in  - unused
//           uio_out - channels 15:8
//           uio_oe  - constant 8'hFF
// Config  : define PWM_EN to build the PWM counter and duty compare;
//           otherwise pwm is tied high and channel i = en_out[i].

// SPI receiver and register file. Registers: 0x00/0x01 en_out, 0x02/0x03
// en_pwm, 0x04 duty.
module uwasic_onboarding_ryan_wang_spi #(
  parameter logic [6:0] MAX_ADDR = 7'h04
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  uwasic_onboarding_ryan_wang_if.slave        spi,
  output logic [15:0]                         en_out_o,
  output logic [15:0]                         en_pwm_o,
  output logic [7:0]                          duty_o
);
  logic [1:0]  sclk_sync_q, copi_sync_q, ncs_sync_q;
  logic        sclk_prev_q, ncs_prev_q;
  logic        sclk_rise, ncs_rise, ncs_fall, commit;
  logic [15:0] shift_q, shift_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] en_out_q, en_out_d, en_pwm_q, en_pwm_d;
  logic [7:0]  duty_q, duty_d;

  assign sclk_rise = sclk_sync_q[1] & ~sclk_prev_q;
  assign ncs_rise  = ncs_sync_q[1] & ~ncs_prev_q;
  assign ncs_fall  = ~ncs_sync_q[1] & ncs_prev_q;

  assign commit = ncs_rise && (bit_cnt_q == 5'd16) && shift_q[15] &&
                  (shift_q[14:8] <= MAX_ADDR);

  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    en_out_d  = en_out_q;
    en_pwm_d  = en_pwm_q;
    duty_d    = duty_q;

    if (ncs_fall || ncs_rise) begin
      shift_d   = '0;
      bit_cnt_d = '0;
    end else if (sclk_rise && !ncs_sync_q[1]) begin
      if (bit_cnt_q < 5'd16) begin
        shift_d   = {shift_q[14:0], copi_sync_q[1]};
        bit_cnt_d = bit_cnt_q + 5'd1;
      end else begin
        // Overlong frame: park the count at 17 so the commit check fails.
        bit_cnt_d = 5'd17;
      end
    end

    if (commit) begin
      case (shift_q[14:8])
        7'h00:   en_out_d[7:0]  = shift_q[7:0];
        7'h01:   en_out_d[15:8] = shift_q[7:0];
        7'h02:   en_pwm_d[7:0]  = shift_q[7:0];
        7'h03:   en_pwm_d[15:8] = shift_q[7:0];
        7'h04:   duty_d         = shift_q[7:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sclk_sync_q <= '0;
      copi_sync_q <= '0;
      ncs_sync_q  <= '0;
      sclk_prev_q <= 1'b0;
      ncs_prev_q  <= 1'b0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      en_out_q    <= '0;
      en_pwm_q    <= '0;
      duty_q      <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], spi.sclk};
      copi_sync_q <= {copi_sync_q[0], spi.copi};
      ncs_sync_q  <= {ncs_sync_q[0], spi.ncs};
      sclk_prev_q <= sclk_sync_q[1];
      ncs_prev_q  <= ncs_sync_q[1];
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      en_out_q    <= en_out_d;
      en_pwm_q    <= en_pwm_d;
      duty_q      <= duty_d;
    end
  end

  assign en_out_o = en_out_q;
  assign en_pwm_o = en_pwm_q;
  assign duty_o   = duty_q;
endmodule

module uwasic_onboarding_ryan_wang #(
  parameter int         CLK_DIV  = 3333,
  parameter logic [6:0] MAX_ADDR = 7'h04
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  logic [15:0] en_out, en_pwm, chan;
  logic [7:0]  duty;
  logic        pwm;
  logic        unused_ok;

  assign unused_ok = &{1'b0, ena, uio_in, ui_in[7:3]};

  uwasic_onboarding_ryan_wang_if spi_bus ();
  assign spi_bus.sclk = ui_in[0];
  assign spi_bus.copi = ui_in[1];
  assign spi_bus.ncs  = ui_in[2];

  uwasic_onboarding_ryan_wang_spi #(.MAX_ADDR(MAX_ADDR)) u_spi (
    .clk_i    (clk),
    .rst_i    (rst_n),
    .spi      (spi_bus.slave),
    .en_out_o (en_out),
    .en_pwm_o (en_pwm),
    .duty_o   (duty)
  );

`ifdef PWM_EN
  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [31:0]      duty_prod, duty_thresh;

  assign pwm_cnt_d = (pwm_cnt_q == CNT_W'(CLK_DIV - 1)) ? '0 : pwm_cnt_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst_n) pwm_cnt_q <= '0;
    else       pwm_cnt_q <= pwm_cnt_d;
  end

  // Full-width product so (duty*CLK_DIV)>>8 loses nothing before the shift.
  assign duty_prod   = 32'(duty) * 32'(CLK_DIV);
  assign duty_thresh = duty_prod >> 8;
  assign pwm = (duty == 8'hFF) | (32'(pwm_cnt_q) < duty_thresh);
`else
  logic unused_pwm;
  assign unused_pwm = &{1'b0, duty};
  assign pwm = 1'b1;
`endif

  assign chan    = en_out & (~en_pwm | {16{pwm}});
  assign uo_out  = rst_n ? 8'h00 : chan[7:0];
  assign uio_out = rst_n ? 8'h00 : chan[15:8];
  assign uio_oe  = 8'hFF;
endmodule

// File: tb/tb_uwasic_onboarding_ryan_wang.sv
`timescale 1ns/1ps
module tb_uwasic_onboarding_ryan_wang;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena = 1'b1;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int vectors = 0;
  int miscompares = 0;

  // Reference register image, indexed by SPI address.
  logic [7:0] m_reg [5];

  always #50 clk = ~clk;

  uwasic_onboarding_ryan_wang_if spi ();
  assign ui_in = {5'b00000, spi.ncs, spi.copi, spi.sclk};

  uwasic_onboarding_ryan_wang dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    vectors++;
    assert (obs >= lo && obs <= hi) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 5; i++) m_reg[i] = 8'h00;
  endtask

  task automatic model_apply(input logic [15:0] f, input int nbits);
    if (nbits == 16 && f[15] && f[14:8] <= 7'h04) m_reg[int'(f[14:8])] = f[7:0];
  endtask

  // Compare all 16 channels against the register image; PWM-driven channels
  // whose level depends on counter phase are masked out.
  task automatic check_outputs(input string tag);
    logic [15:0] eo, ep, exp, indet, obs;
    logic        pb;
    eo = {m_reg[1], m_reg[0]};
    ep = {m_reg[3], m_reg[2]};
`ifdef PWM_EN
    pb    = (m_reg[4] == 8'hFF);
    indet = (m_reg[4] == 8'h00 || m_reg[4] == 8'hFF) ? 16'h0000 : (eo & ep);
`else
    pb    = 1'b1;
    indet = 16'h0000;
`endif
    exp = eo & (~ep | {16{pb}});
    obs = {uio_out, uo_out};
    vectors++;
    assert ((obs & ~indet) === (exp & ~indet)) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h (mask %h)", tag, obs, exp, indet);
    end
  endtask

  task automatic spi_bits(input logic [15:0] f, input int nbits);
    logic [15:0] sh;
    sh = f;
    for (int i = 0; i < nbits; i++) begin
      spi.copi = (i < 16) ? sh[15] : 1'($urandom_range(1));
      sh = sh << 1;
      clks(3);
      spi.sclk = 1'b1;
      clks(3);
      spi.sclk = 1'b0;
    end
  endtask

  // Full frame; returns 4 clk after nCS rises so callers check the latency bound.
  task automatic spi_frame(input logic [15:0] f, input int nbits);
    spi.ncs = 1'b0;
    clks(4);
    spi_bits(f, nbits);
    clks(3);
    spi.ncs = 1'b1;
    clks(4);
  endtask

  task automatic write_reg(input logic [6:0] a, input logic [7:0] d);
    logic [15:0] f;
    f = {1'b1, a, d};
    spi_frame(f, 16);
    model_apply(f, 16);
  endtask

  initial begin
    int  h, l, cnt, nb;
    logic prev, got;
    logic [15:0] f;

    spi.sclk = 1'b0;
    spi.copi = 1'b0;
    spi.ncs  = 1'b1;
    rst_n    = 1'b1;
    model_clear();
    clks(3);
    check8("reset_uo_out", uo_out, 8'h00);
    check8("reset_uio_out", uio_out, 8'h00);
    check8("reset_uio_oe", uio_oe, 8'hFF);
    rst_n = 1'b0;
    clks(4);
    check_outputs("post_reset");

    write_reg(7'h00, 8'hF0);
    check8("wr0_uo_out", uo_out, 8'hF0);
    write_reg(7'h01, 8'hCC);
    check8("wr1_uio_out", uio_out, 8'hCC);
    check8("wr1_uo_out", uo_out, 8'hF0);

    f = 16'hB0FF; spi_frame(f, 16); model_apply(f, 16);
    check_outputs("bad_addr_0x30");
    f = 16'h80FF; spi_frame(f, 15); model_apply(f, 15);
    check_outputs("short_15bit");
    f = 16'h80FF; spi_frame(f, 17); model_apply(f, 17);
    check_outputs("long_17bit");
    f = 16'h00FF; spi_frame(f, 16); model_apply(f, 16);
    check8("read_uo_out", uo_out, 8'hF0);
    check8("read_uio_out", uio_out, 8'hCC);

    write_reg(7'h00, 8'h01);
    write_reg(7'h01, 8'h00);
    write_reg(7'h02, 8'h01);
    write_reg(7'h04, 8'h80);
`ifdef PWM_EN
    got = 1'b0;
    prev = uo_out[0];
    for (int i = 0; i < 8000 && !got; i++) begin
      clks(1);
      if (!prev && uo_out[0]) got = 1'b1;
      prev = uo_out[0];
    end
    check_range("pwm_rise_seen", int'(got), 1, 1);
    h = 0;
    while (uo_out[0] && h < 8000) begin clks(1); h++; end
    l = 0;
    while (!uo_out[0] && l < 8000) begin clks(1); l++; end
    check_range("pwm_high_clks", h, 1665, 1667);
    check_range("pwm_period_clks", h + l, 3332, 3334);

    write_reg(7'h04, 8'h00);
    cnt = 0;
    for (int i = 0; i < 3400; i++) begin clks(1); if (uo_out[0]) cnt++; end
    check_range("duty00_high_count", cnt, 0, 0);
    write_reg(7'h04, 8'hFF);
    cnt = 0;
    for (int i = 0; i < 3400; i++) begin clks(1); if (!uo_out[0]) cnt++; end
    check_range("dutyFF_low_count", cnt, 0, 0);
`else
    cnt = 0;
    for (int i = 0; i < 500; i++) begin clks(1); if (!uo_out[0]) cnt++; end
    check_range("nopwm_low_count", cnt, 0, 0);
`endif
    check_outputs("after_pwm");

    // Reset in the middle of a frame; the tail of that frame must not commit.
    write_reg(7'h00, 8'h3C);
    spi.ncs = 1'b0;
    clks(4);
    spi_bits(16'h81AA, 8);
    rst_n = 1'b1;
    clks(3);
    check8("midreset_uo_out", uo_out, 8'h00);
    check8("midreset_uio_out", uio_out, 8'h00);
    model_clear();
    rst_n = 1'b0;
    clks(2);
    spi_bits(16'hAA00, 8);
    clks(3);
    spi.ncs = 1'b1;
    clks(4);
    check_outputs("aborted_frame");
    write_reg(7'h01, 8'h55);
    check8("after_abort_uio_out", uio_out, 8'h55);

    for (int it = 0; it < 40; it++) begin
      f[15] = ($urandom_range(3) != 0);
      f[14:8] = ($urandom_range(7) == 0) ? 7'($urandom) : 7'($urandom_range(4));
      f[7:0] = 8'($urandom);
      case ($urandom_range(9))
        0:       nb = 15;
        1:       nb = 17;
        default: nb = 16;
      endcase
      spi_frame(f, nb);
      model_apply(f, nb);
      check_outputs($sformatf("random_%0d", it));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uwasic_onboarding_ryan_wang.md
# uwasic_onboarding_ryan_wang

SPI-configured 16-channel output controller with a shared PWM generator, forming the top level of a Tiny Tapeout user tile. An external SPI host writes five 8-bit configuration registers; each of 16 outputs is then driven static-low, static-high or PWM according to those registers. Outputs 7:0 appear on `uo_out`, and outputs 15:8 appear on `uio_out`.

## Interface
Parameters:
- `CLK_DIV`, default 3333: PWM period in clk cycles (3.0 kHz at 10 MHz).
- `MAX_ADDR`, default 7'h04: highest valid register address.

Ports:
- `clk`  input  1  system clock, 10 MHz nominal.
- `rst_n`  input  1  reset; synchronous, active-high (asserted when 1).
- `ena`  input  1  tile select; ignored.
- `ui_in`  input  8  [0]=SCLK, [1]=COPI, [2]=nCS; [7:3] unused.
- `uo_out`  output  8  channel outputs 7:0.
- `uio_in`  input  8  unused.
- `uio_out`  output  8  channel outputs 15:8.
- `uio_oe`  output  8  constant 8'hFF.

## Operation
- Registers, all reset to 8'h00:
  - 0x00 `en_out[7:0]`
  - 0x01 `en_out[15:8]`
  - 0x02 `en_pwm[7:0]`
  - 0x03 `en_pwm[15:8]`
  - 0x04 `duty`
- SPI is mode 0, MSB first. A frame is 16 bits: bit15 R/W (1=write), bits14:8 address, bits7:0 data.
- SCLK, COPI and nCS each pass through a 2-FF synchronizer into `clk`.
- COPI is sampled on each detected SCLK rising edge while nCS is low. The shift register and bit counter clear on nCS falling.
- Commit happens on nCS rising, only if all of these hold:
  - exactly 16 bits were received
  - R/W=1
  - address ≤ MAX_ADDR
- Frames failing any condition are discarded: no register changes. Bits beyond 16 are ignored, and the frame is then discarded because the count is not 16.
- Reads (R/W=0) are accepted and discarded; there is no read-back data path.
- PWM counter runs 0..CLK_DIV-1, then wraps to 0, free-running.
- `pwm` = 1 when duty==8'hFF; otherwise `pwm` = (counter < (duty*CLK_DIV)>>8). Duty 0 gives constant 0.
- Output channel i = `en_out[i]` ? (`en_pwm[i]` ? `pwm` : 1) : 0.
- Arithmetic: the duty×CLK_DIV product is computed at ≥20 bits with no truncation before the shift.

## Timing
- Reset: all registers, shift state, synchronizers and the PWM counter clear. `uo_out`=`uio_out`=0 and `uio_oe`=8'hFF during and after reset.
- Register update lands ≤4 clk after nCS rises at the pin (2-FF sync + edge detect + commit).
- SCLK must be ≤ clk/4. Each SCLK high and low phase must last ≥2 clk.
- Register outputs feed the output logic combinationally from flops. PWM changes take effect at the current counter position, with no period-boundary sync.
- Reset asserted mid-frame aborts the frame. The frame is not committed after reset releases.
- nCS rising with fewer than 16 bits: discard, and the next frame starts clean.

## Configuration
- `PWM_EN` defined:
  - PWM counter and duty compare are present, as described above.
- `PWM_EN` undefined:
  - No counter is built, and `pwm` is tied to 1, so output i = `en_out[i]`.
  - Registers 0x02–0x04 remain writable, but have no effect on outputs.

## Test plan
- Reset → `uo_out`=0x00, `uio_out`=0x00, `uio_oe`=0xFF.
- Write 0x00←0xF0 and 0x01←0xCC → `uo_out`=0xF0, `uio_out`=0xCC within 4 clk of nCS rising.
- Write to address 0x30, and send a 15-bit frame to 0x00 → no output change.
- `en_out[0]`=1, `en_pwm[0]`=1, duty=0x80 → `uo_out[0]` period 3333±1 clk, high 1666±1 clk. Duty 0x00 → constant 0. Duty 0xFF → constant 1.
- Read frame (R/W=0) to 0x00 with data 0xFF → registers unchanged.
- Assert reset mid-frame → outputs 0; the next full write frame commits normally.
